// File: rtl/avg8_seq_ctrl_if.sv
// Sample/result handshake bundle for avg8_seq_ctrl.
// slave = averaging block, master = producer/consumer side.
interface avg8_seq_ctrl_if #(
    parameter int DATAWIDTH = 16
);
    logic [7:0]           Sa;
    logic                 InValid;
    logic                 InReady;
    logic [DATAWIDTH-1:0] InData;
    logic                 OutValid;
    logic                 OutReady;
    logic [DATAWIDTH-1:0] Avg;
    logic                 Busy;

    modport slave (
        input  Sa, InValid, InData, OutReady,
        output InReady, OutValid, Avg, Busy
    );

    modport master (
        output Sa, InValid, InData, OutReady,
        input  InReady, OutValid, Avg, Busy
    );
endinterface

// File: rtl/avg8_seq_ctrl.sv
// Resource-shared averager: one adder, one shifter, time-multiplexed by an FSM.
// Optional AVG8_SEQ_CTRL_SATURATE_EN clamps the result instead of truncating.
module avg8_seq_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int ACCW      = 32,
    parameter int NSAMP     = 8,
    parameter int NSHIFT    = 3
) (
    input logic             Clk,
    input logic             Rst,
    avg8_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(NSAMP + 1);
    localparam int SW = $clog2(NSHIFT + 1);
    localparam logic [8:0] ACCW_L = 9'(ACCW);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    logic [ACCW-1:0]      acc;
    logic [ACCW-1:0]      data_ext;
    logic [ACCW-1:0]      shifted;
    logic [CW-1:0]        cnt;
    logic [SW-1:0]        shcnt;
    logic [7:0]           sa_reg;
    logic [DATAWIDTH-1:0] avg;
    logic [DATAWIDTH-1:0] res;
    logic                 accept;
    logic                 take;

    assign data_ext = ACCW'(bus.InData);
    assign accept   = bus.InValid & bus.InReady;
    assign take     = bus.OutValid & bus.OutReady;

    // Oversized shift amounts flush to zero explicitly.
    assign shifted = ({1'b0, sa_reg} >= ACCW_L) ? '0 : (acc >> sa_reg);

`ifdef AVG8_SEQ_CTRL_SATURATE_EN
    always_comb begin
        res = shifted[DATAWIDTH-1:0];
        if (|shifted[ACCW-1:DATAWIDTH])
            res = '1;
    end
`else
    always_comb begin
        res = shifted[DATAWIDTH-1:0];
    end
`endif

    // Handshake flags are pure state decodes; InReady is masked by reset.
    assign bus.InReady  = ~Rst & ((state == IDLE) | (state == ACCUM));
    assign bus.OutValid = (state == DONE);
    assign bus.Busy     = (state != IDLE);
    assign bus.Avg      = avg;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            shcnt  <= '0;
            sa_reg <= '0;
            avg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc    <= data_ext;
                        sa_reg <= bus.Sa;
                        cnt    <= CW'(1);
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + data_ext;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NSAMP - 1)) begin
                            shcnt <= '0;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= shifted;
                    shcnt <= shcnt + SW'(1);
                    if (shcnt == SW'(NSHIFT - 1)) begin
                        avg   <= res;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (take)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/avg8_seq_ctrl.md
Name: avg8_seq_ctrl

Overview:
- Sequential, resource-shared version of the 8-input averaging datapath: one 32-bit adder and one logical right shifter, time-multiplexed by an FSM.
- Accepts DATAWIDTH-bit samples serially over a valid/ready handshake and accumulates NSAMP of them.
- Applies NSHIFT successive right shifts by a captured shift amount, then presents the truncated result on a valid/ready output.
- Sits between a sample producer and a result consumer in place of the fully parallel adder tree.

Parameters:
DATAWIDTH, 16, sample and result width
ACCW, 32, accumulator/shifter width; must be >= DATAWIDTH + log2(NSAMP)
NSAMP, 8, samples per frame; must be >= 2
NSHIFT, 3, number of shift passes applied per frame; must be >= 1

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  reset, synchronous, active-high
Sa  input  8  shift amount per pass; sampled only on first accepted sample of a frame
InValid  input  1  producer has a sample on InData
InReady  output  1  block accepts a sample this cycle
InData  input  DATAWIDTH  sample, unsigned
OutValid  output  1  Avg holds a completed result
OutReady  input  1  consumer takes the result this cycle
Avg  output  DATAWIDTH  result, registered
Busy  output  1  frame in progress (ACCUM, SHIFT or DONE)

Behaviour:
- Reset (Rst high at rising edge):
  - State → IDLE; acc, cnt, shcnt, sa_reg, Avg → 0; OutValid → 0; Busy → 0.
  - InReady is forced to 0 while Rst is high.
  - Reset mid-frame discards partial accumulation; no output is produced.
- Accept event: InValid & InReady at a rising edge. Output event: OutValid & OutReady at a rising edge.
- InReady, OutValid and Busy are Moore outputs decoded from state.
- IDLE (InReady=1, Busy=0):
  - On accept: acc ← zero-extended InData; sa_reg ← Sa; cnt ← 1; → ACCUM.
- ACCUM (InReady=1, Busy=1):
  - On accept: acc ← (acc + zext(InData)) mod 2^ACCW; cnt ← cnt+1.
  - If cnt == NSAMP-1 at that accept: shcnt ← 0; → SHIFT.
  - No accept: all state holds. Gaps in InValid are allowed.
- SHIFT (InReady=0, Busy=1):
  - Every cycle: acc ← acc >> sa_reg (logical, zero fill); sa_reg >= ACCW yields 0. shcnt ← shcnt+1.
  - On the NSHIFT-th shift: Avg ← shifted value[DATAWIDTH-1:0]; → DONE.
- DONE (OutValid=1, InReady=0, Busy=1):
  - On output event → IDLE; OutValid deasserts the following cycle.
  - Avg holds its value until the next frame's load, including after the handshake.
- Latency: if the last sample is accepted at edge k, OutValid is high in the cycle after edge k+NSHIFT. Minimum frame period is NSAMP + NSHIFT + 1 cycles.
- Changes on Sa after the first accept of a frame are ignored.
- No overlap: a new frame cannot start until the result is taken.
- Avg truncation: bits above DATAWIDTH-1 are dropped, unless SATURATE_EN is defined.

Optional Feature:
- Macro: AVG8_SEQ_CTRL_SATURATE_EN.
- Defined: on the final shift, if shifted value >= 2^DATAWIDTH, Avg ← all ones; otherwise Avg ← value[DATAWIDTH-1:0].
- Undefined: plain truncation to [DATAWIDTH-1:0]; no comparator is synthesised.
- Handshake and timing are identical in both builds.

Test Plan:
1. Samples 1..8 back-to-back, Sa=1, OutReady=1 → Avg=4 (36>>3); OutValid rises 3 cycles after last accept, lasts 1 cycle; InReady=0 during SHIFT/DONE.
2. Eight samples 0xFFFF, Sa=1 → acc=524280; Avg=0xFFFF; no wrap.
3. Eight samples 0x4000, Sa=0 → Avg=0x0000 without macro; Avg=0xFFFF with AVG8_SEQ_CTRL_SATURATE_EN.
4. Samples 10 each with random InValid gaps, Sa changed to 7 after first accept (initial 1), OutReady low 5 cycles → Avg=10; OutValid and Avg stable while stalled; InReady=0 until output event.
5. Rst pulsed after 4 accepts, then 8 samples of 2, Sa=1 → no output from aborted frame; Avg=2; Busy=0 in the cycle after reset.
6. Sa=40, any nonzero samples → Avg=0; timing as in scenario 1.
